// File: rtl/barcode_id_rcv.sv
// Self-timed serial station-barcode receiver: one 8-bit ID per frame, sticky valid with clear handshake.
// Define BC_TIMEOUT_EN to abort a frame that stalls in WAIT_FALL for TIMEOUT_CYC cycles.
module barcode_id_rcv #(
  parameter int CNT_W       = 22,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld
);

  // state     | meaning
  // IDLE      | line idle, waiting for the start-bit falling edge
  // MEASURE   | timing the start-bit low pulse into period
  // WAIT_FALL | waiting for the next bit's falling edge
  // SAMPLE    | counting to period, then sampling the line
  // DONE      | one cycle: publish the ID if it is a station ID
  typedef enum logic [2:0] {IDLE, MEASURE, WAIT_FALL, SAMPLE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             bc_s1_q, bc_s2_q, bc_prev_q;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       id_q, id_d;
  logic             id_vld_q, id_vld_d;
  logic             fall, rise;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  assign fall   = bc_prev_q & ~bc_s2_q;
  assign rise   = ~bc_prev_q & bc_s2_q;
  assign ID     = id_q;
  assign ID_vld = id_vld_q;

`ifdef BC_TIMEOUT_EN
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] idle_q, idle_d;

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`endif

  // Synchronizer and edge flops reset high so reset release never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      bc_s1_q   <= 1'b1;
      bc_s2_q   <= 1'b1;
      bc_prev_q <= 1'b1;
      state_q   <= IDLE;
      period_q  <= '0;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      id_q      <= '0;
      id_vld_q  <= 1'b0;
    end else begin
      bc_s1_q   <= BC;
      bc_s2_q   <= bc_s1_q;
      bc_prev_q <= bc_s2_q;
      state_q   <= state_d;
      period_q  <= period_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      id_q      <= id_d;
      id_vld_q  <= id_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    id_d      = id_q;
    id_vld_d  = clr_ID_vld ? 1'b0 : id_vld_q;
`ifdef BC_TIMEOUT_EN
    idle_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (fall) begin
          period_d = CNT_ONE;
          state_d  = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          bit_cnt_d = '0;
          state_d   = WAIT_FALL;
        end else if (!bc_s2_q && period_q != CNT_MAX) begin
          period_d = period_q + CNT_ONE;
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          timer_d = CNT_ONE;
          state_d = SAMPLE;
        end
`ifdef BC_TIMEOUT_EN
        else if (idle_q == IDLE_LAST) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          idle_d = idle_q + CNT_ONE;
        end
`endif
      end
      SAMPLE: begin
        // Rises before the sample point are short '1' pulses and are deliberately ignored.
        if (timer_q == period_q) begin
          shift_d   = {shift_q[6:0], bc_s2_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
          state_d   = (bit_cnt_q == 4'd7) ? DONE : WAIT_FALL;
        end else if (timer_q != CNT_MAX) begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      DONE: begin
        if (shift_q[7:6] == 2'b00) begin
          id_d     = shift_q;
          id_vld_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_barcode_id_rcv.sv
// Self-checking bench for barcode_id_rcv: frame table plus hand sequences, scoreboard checks exact ID latency.
module tb_barcode_id_rcv;

  logic       clk = 1'b0;
  logic       rst, BC, clr_ID_vld;
  logic [7:0] ID;
  logic       ID_vld;

  barcode_id_rcv #(.CNT_W(22), .TIMEOUT_CYC(500)) dut (
    .clk(clk), .rst(rst), .BC(BC), .clr_ID_vld(clr_ID_vld), .ID(ID), .ID_vld(ID_vld)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         start_lo;
    int         slot;
    int         one_lo;
    int         zero_lo;
    logic [7:0] data;
    bit         clr_before;
    bit         clr_on_done;
    logic [7:0] exp_id;
    logic       exp_vld;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] id;
    bit         clr_on_done;
  } sb_t;

  sb_t        sb_q[$];
  vec_t       vecs[9];
  vec_t       v11;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] m_id;
  logic       m_vld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every clock goes through here so the scoreboard sees each cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() > 0) begin
      if (cyc == sb_q[0].due - 1) begin
        check("pre_latency_id", ID, m_id);
        check("pre_latency_vld", ID_vld, m_vld);
        if (sb_q[0].clr_on_done) clr_ID_vld = 1'b1;
      end else if (cyc == sb_q[0].due) begin
        if (sb_q[0].clr_on_done) clr_ID_vld = 1'b0;
        check("due_id", ID, sb_q[0].id);
        check("due_vld", ID_vld, 1'b1);
        m_id  = sb_q[0].id;
        m_vld = 1'b1;
        void'(sb_q.pop_front());
      end
    end
  endtask

  task automatic drive(input logic val, input int n);
    BC = val;
    repeat (n) tick();
  endtask

  task automatic clr_pulse();
    clr_ID_vld = 1'b1;
    tick();
    clr_ID_vld = 1'b0;
    m_vld = 1'b0;
  endtask

  task automatic send_start(input int start_lo);
    drive(1'b0, start_lo);
    drive(1'b1, 2 * start_lo);
  endtask

  // Output lands 4 + start_lo edges after the edge that launches the last bit's fall.
  task automatic send_bits(input logic [7:0] data, input int hi, input int lo, input int slot,
                           input int one_lo, input int zero_lo, input bit clr_on_done,
                           input int start_lo);
    for (int i = hi; i >= lo; i--) begin
      int lo_len;
      lo_len = data[i] ? one_lo : zero_lo;
      if (i == 0 && data[7:6] == 2'b00) sb_q.push_back('{cyc + 4 + start_lo, data, clr_on_done});
      drive(1'b0, lo_len);
      drive(1'b1, slot - lo_len);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    if (v.clr_before) clr_pulse();
    send_start(v.start_lo);
    send_bits(v.data, 7, 0, v.slot, v.one_lo, v.zero_lo, v.clr_on_done, v.start_lo);
    drive(1'b1, 20);
    check("frame_id", ID, v.exp_id);
    check("frame_vld", ID_vld, v.exp_vld);
  endtask

  initial begin
    //          start slot  one  zero  data   clrb  clrd  exp_id exp_vld
    vecs[0] = '{100,  300,  40,  160,  8'h15, 1'b0, 1'b0, 8'h15, 1'b1};
    vecs[1] = '{100,  300,  40,  160,  8'h95, 1'b0, 1'b0, 8'h15, 1'b0};
    vecs[2] = '{100,  300,  40,  160,  8'h2A, 1'b0, 1'b0, 8'h2A, 1'b1};
    vecs[3] = '{100,  300,  40,  160,  8'h15, 1'b0, 1'b0, 8'h15, 1'b1};
    vecs[4] = '{100,  300,  40,  160,  8'h0C, 1'b0, 1'b1, 8'h0C, 1'b1};
    vecs[5] = '{100,  300,  40,  160,  8'h07, 1'b0, 1'b0, 8'h07, 1'b1};
    vecs[6] = '{3,    9,    1,   5,    8'h3F, 1'b1, 1'b0, 8'h3F, 1'b1};
    vecs[7] = '{250,  750,  100, 400,  8'h3F, 1'b1, 1'b0, 8'h3F, 1'b1};
    vecs[8] = '{1000, 3000, 400, 1600, 8'h3F, 1'b1, 1'b0, 8'h3F, 1'b1};
    v11     = '{100,  300,  40,  160,  8'h11, 1'b1, 1'b0, 8'h11, 1'b1};

    BC = 1'b1; clr_ID_vld = 1'b0; rst = 1'b1;
    m_id = 8'h00; m_vld = 1'b0;
    repeat (3) tick();
    check("reset_id", ID, 8'h00);
    check("reset_vld", ID_vld, 1'b0);
    rst = 1'b0;
    drive(1'b1, 5);

    for (int i = 0; i <= 4; i++) begin
      apply_vec(vecs[i]);
      if (i == 0) begin
        drive(1'b1, 50);
        check("vld_sticky", ID_vld, 1'b1);
        clr_pulse();
        check("vld_cleared", ID_vld, 1'b0);
      end
    end

    // Reset after the 4th bit discards the partial frame.
    send_start(100);
    send_bits(8'h07, 7, 4, 300, 40, 160, 1'b0, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_id = 8'h00; m_vld = 1'b0;
    check("midframe_rst_id", ID, 8'h00);
    check("midframe_rst_vld", ID_vld, 1'b0);
    drive(1'b1, 5);

    for (int i = 5; i <= 8; i++) apply_vec(vecs[i]);

    // Line stalls high for 600 cycles after the 3rd bit.
    clr_pulse();
    send_start(100);
    send_bits(8'h22, 7, 5, 300, 40, 160, 1'b0, 100);
    drive(1'b1, 600);
`ifdef BC_TIMEOUT_EN
    check("timeout_vld", ID_vld, 1'b0);
    check("timeout_id", ID, 8'h3F);
`else
    send_bits(8'h22, 4, 0, 300, 40, 160, 1'b0, 100);
    drive(1'b1, 20);
    check("stall_id", ID, 8'h22);
    check("stall_vld", ID_vld, 1'b1);
`endif
    apply_vec(v11);

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
